// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions: RV32I load/store funct3 codes, byte-lane
// patterns, arbiter state encoding and the per-port request payload.
package rv_mem_pkg;

  localparam int unsigned NPORT  = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned MASK_W = 4;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  localparam logic [MASK_W-1:0] PAT_BYTE = 4'b0001;
  localparam logic [MASK_W-1:0] PAT_HALF = 4'b0011;
  localparam logic [MASK_W-1:0] PAT_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   func3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // True when funct3 names an access the memory can perform in that direction.
  function automatic logic f3_legal(input logic we, input logic [F3_W-1:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_bmask_gen.sv
// Byte-lane mask generator: splits an access pattern shifted by the byte
// offset into the aligned word lanes and the spill-over lanes of the next word.
module lsu_bmask_gen
  import rv_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  output logic [MASK_W-1:0] bmask_align_c,
  output logic [MASK_W-1:0] bmask_misalign_c
);

  logic [MASK_W-1:0]   pat;
  logic [2*MASK_W-1:0] shifted;

  always_comb begin
    pat = '0;
    case (size)
      2'b00:   pat = PAT_BYTE;
      2'b01:   pat = PAT_HALF;
      2'b10:   pat = PAT_WORD;
      default: pat = '0;
    endcase
    shifted          = (2*MASK_W)'(pat) << offset;
    bmask_align_c    = shifted[MASK_W-1:0];
    bmask_misalign_c = shifted[2*MASK_W-1:MASK_W];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one requester per idle cycle, issues
// stores back-to-back and holds off new grants while a load response returns.
module dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NPORT-1:0]              i_req_valid,
  output logic [NPORT-1:0]              o_req_ready,
  input  logic [NPORT-1:0]              i_req_we,
  input  logic [NPORT-1:0][F3_W-1:0]    i_req_func3,
  input  logic [NPORT-1:0][ADDR_W-1:0]  i_req_addr,
  input  logic [NPORT-1:0][DATA_W-1:0]  i_req_wdata,
  output logic [NPORT-1:0]              o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [F3_W-1:0]               o_mem_func3,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  output logic [MASK_W-1:0]             o_mem_bmask_align,
  output logic [MASK_W-1:0]             o_mem_bmask_misalign,
  output logic                          o_mem_wren,
  output logic                          o_mem_rden,
  input  logic [DATA_W-1:0]             i_mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q;
  logic              rsp_port_q;
  logic              rsp_err_q;
  logic              gnt_vld;
  logic              gnt_idx;
  logic              sel_legal;
  mem_req_t          sel_req;
  logic [MASK_W-1:0] bm_align_c, bm_misalign_c;

  // Grant decode; reset is folded in so nothing is offered while it is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (i_reset && (state_q == ST_IDLE) && (i_req_valid != '0)) begin
      gnt_vld = 1'b1;
      if (&i_req_valid) begin
        gnt_idx = RR_EN ? ~last_gnt_q : 1'b0;
      end else begin
        gnt_idx = i_req_valid[1];
      end
    end
    sel_req   = '{we:    i_req_we[gnt_idx],
                  func3: i_req_func3[gnt_idx],
                  addr:  i_req_addr[gnt_idx],
                  wdata: i_req_wdata[gnt_idx]};
    sel_legal = f3_legal(sel_req.we, sel_req.func3);
  end

  lsu_bmask_gen u_bmask (
    .size             (sel_req.func3[1:0]),
    .offset           (sel_req.addr[1:0]),
    .bmask_align_c    (bm_align_c),
    .bmask_misalign_c (bm_misalign_c)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remember who was served and how its response must look.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      last_gnt_q <= 1'b1;
      rsp_port_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (gnt_vld) begin
      last_gnt_q <= gnt_idx;
      rsp_port_q <= gnt_idx;
      rsp_err_q  <= ~sel_legal;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld && !(sel_req.we && sel_legal)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready          = '0;
    o_mem_func3          = '0;
    o_mem_addr           = '0;
    o_mem_wdata          = '0;
    o_mem_bmask_align    = '0;
    o_mem_bmask_misalign = '0;
    o_mem_wren           = 1'b0;
    o_mem_rden           = 1'b0;
    o_rsp_valid          = '0;
    o_rsp_rdata          = '0;
    o_rsp_err            = 1'b0;
    if (gnt_vld) begin
      o_req_ready[gnt_idx] = 1'b1;
      o_mem_func3          = sel_req.func3;
      o_mem_addr           = sel_req.addr;
      o_mem_wdata          = sel_req.wdata;
      o_mem_wren           = sel_req.we && sel_legal;
      o_mem_rden           = !sel_req.we && sel_legal;
      if (sel_req.we && sel_legal) begin
        o_mem_bmask_align    = bm_align_c;
        o_mem_bmask_misalign = bm_misalign_c;
      end
    end
    // Memory read data arrives one cycle after rden, i.e. during RESP.
    if (state_q == ST_RESP) begin
      o_rsp_valid[rsp_port_q] = 1'b1;
      o_rsp_err               = rsp_err_q;
      o_rsp_rdata             = rsp_err_q ? '0 : i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus held-request random traffic
// checked against a byte-addressed reference memory and a grant/response model.
module tb_dmem_arbiter;
  import rv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_we;
  logic [1:0][2:0]  req_func3;
  logic [1:0][15:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      mem_rdata;

  logic [1:0]  o_req_ready, o_rsp_valid;
  logic [31:0] o_rsp_rdata, o_mem_wdata;
  logic        o_rsp_err, o_mem_wren, o_mem_rden;
  logic [2:0]  o_mem_func3;
  logic [15:0] o_mem_addr;
  logic [3:0]  o_mem_bmask_align, o_mem_bmask_misalign;

  logic [1:0]  fp_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_rdata, fp_wdata;
  logic        fp_rsp_err, fp_wren, fp_rden;
  logic [2:0]  fp_func3;
  logic [15:0] fp_addr;
  logic [3:0]  fp_al, fp_mis;

  dmem_arbiter #(.RR_EN(1'b1)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_we(req_we), .i_req_func3(req_func3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_mem_func3(o_mem_func3), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask_align(o_mem_bmask_align),
    .o_mem_bmask_misalign(o_mem_bmask_misalign), .o_mem_wren(o_mem_wren),
    .o_mem_rden(o_mem_rden), .i_mem_rdata(mem_rdata));

  dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(fp_ready),
    .i_req_we(req_we), .i_req_func3(req_func3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(fp_rsp_valid), .o_rsp_rdata(fp_rsp_rdata),
    .o_rsp_err(fp_rsp_err), .o_mem_func3(fp_func3), .o_mem_addr(fp_addr),
    .o_mem_wdata(fp_wdata), .o_mem_bmask_align(fp_al),
    .o_mem_bmask_misalign(fp_mis), .o_mem_wren(fp_wren),
    .o_mem_rden(fp_rden), .i_mem_rdata(mem_rdata));

  // Environment memory: writes lanes as the DUT's masks say, returns aligned words.
  bit [7:0] env_mem [0:255];
  int env_base, env_off;
  always @(posedge clk) begin
    env_base = int'(o_mem_addr) & 32'hFC;
    env_off  = int'(o_mem_addr[1:0]);
    if (o_mem_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (o_mem_bmask_align[i])
          env_mem[(env_base + i) & 255] <= o_mem_wdata[8*((i - env_off) & 3) +: 8];
        if (o_mem_bmask_misalign[i])
          env_mem[(env_base + 4 + i) & 255] <= o_mem_wdata[8*((4 + i - env_off) & 3) +: 8];
      end
    end
    if (o_mem_rden)
      mem_rdata <= {env_mem[(env_base + 3) & 255], env_mem[(env_base + 2) & 255],
                    env_mem[(env_base + 1) & 255], env_mem[env_base & 255]};
  end

  // Reference model state: byte memory plus an outstanding-response record.
  bit [7:0]    ref_mem [0:255];
  bit          m_busy, m_port, m_err, m_last;
  logic [15:0] m_addr;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    int b;
    b = int'(a) & 32'hFC;
    return {ref_mem[(b + 3) & 255], ref_mem[(b + 2) & 255],
            ref_mem[(b + 1) & 255], ref_mem[b & 255]};
  endfunction

  task automatic model_check(output bit gok, output int gi);
    logic [1:0]  e_ready, e_rsp;
    logic        e_wren, e_rden, e_err;
    logic [2:0]  e_f3;
    logic [15:0] e_addr;
    logic [31:0] e_wd, e_rd;
    logic [3:0]  e_al, e_mis;
    bit          we, lg;
    int          n, base;
    e_ready = '0; e_rsp = '0; e_wren = 0; e_rden = 0; e_err = 0; e_f3 = '0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_al = '0; e_mis = '0;
    we = 0; lg = 0; n = 0; gok = 0; gi = 0;
    if (rst_n) begin
      if (m_busy) begin
        e_rsp[m_port] = 1'b1;
        e_err = m_err;
        e_rd  = m_err ? 32'h0 : ref_word(m_addr);
      end else if (req_valid != 2'b00) begin
        gok = 1;
        gi  = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[0] ? 0 : 1);
        we     = req_we[gi];
        e_f3   = req_func3[gi];
        e_addr = req_addr[gi];
        e_wd   = req_wdata[gi];
        e_ready[gi] = 1'b1;
        lg = we ? (e_f3 <= 3'd2) : (e_f3 <= 3'd2 || e_f3 == 3'd4 || e_f3 == 3'd5);
        e_wren = we && lg;
        e_rden = !we && lg;
        if (e_wren) begin
          n    = 1 << e_f3[1:0];
          base = int'(e_addr) & ~3;
          for (int i = 0; i < 8; i++) begin
            if (base + i >= int'(e_addr) && base + i < int'(e_addr) + n) begin
              if (i < 4) e_al[i] = 1'b1;
              else       e_mis[i-4] = 1'b1;
            end
          end
        end
      end
    end
    chk("ready",     32'(o_req_ready), 32'(e_ready));
    chk("wren",      32'(o_mem_wren), 32'(e_wren));
    chk("rden",      32'(o_mem_rden), 32'(e_rden));
    chk("mem_func3", 32'(o_mem_func3), 32'(e_f3));
    chk("mem_addr",  32'(o_mem_addr), 32'(e_addr));
    chk("mem_wdata", o_mem_wdata, e_wd);
    chk("bm_align",  32'(o_mem_bmask_align), 32'(e_al));
    chk("bm_misal",  32'(o_mem_bmask_misalign), 32'(e_mis));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rsp));
    chk("rsp_err",   32'(o_rsp_err), 32'(e_err));
    chk("rsp_rdata", o_rsp_rdata, e_rd);
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
    end else if (m_busy) begin
      m_busy = 0;
    end else if (gok) begin
      m_last = gi[0];
      if (e_wren) begin
        for (int k = 0; k < n; k++) ref_mem[(int'(e_addr) + k) & 255] = e_wd[8*k +: 8];
      end else begin
        m_busy = 1; m_port = gi[0]; m_err = !lg; m_addr = e_addr;
      end
    end
  endtask

  task automatic set_req(input int p, input bit v, input bit we,
                         input logic [2:0] f3, input logic [15:0] a, input logic [31:0] d);
    req_valid[p] = v; req_we[p] = we; req_func3[p] = f3; req_addr[p] = a; req_wdata[p] = d;
  endtask

  bit          gok;
  int          gi;
  logic [1:0]  exp_rdy [0:7];
  logic [1:0]  exp_rsp [0:7];
  bit [1:0]    pend;

  initial begin
    rst_n = 1'b0; mem_rdata = '0;
    req_valid = '0; req_we = '0; req_func3 = '0; req_addr = '0; req_wdata = '0;
    m_busy = 0; m_port = 0; m_err = 0; m_last = 1; m_addr = '0;
    @(negedge clk);

    // Reset with both ports requesting: everything quiet.
    set_req(0, 1, 0, F3_LW, 16'h0004, 32'h0);
    set_req(1, 1, 1, F3_SW, 16'h0008, 32'h55AA55AA);
    #1 model_check(gok, gi);
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    @(negedge clk);

    // First cycle after release: store and load on port 0.
    rst_n = 1'b1;
    set_req(0, 1, 1, F3_SW, 16'h0004, 32'hDEADBEEF); set_req(1, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    chk("sw4_wren", 32'(o_mem_wren), 32'h1);
    chk("sw4_al", 32'(o_mem_bmask_align), 32'hF);
    chk("sw4_mis", 32'(o_mem_bmask_misalign), 32'h0);
    @(negedge clk);
    set_req(0, 1, 0, F3_LW, 16'h0004, 32'h0);
    #1 model_check(gok, gi);
    chk("lw4_rden", 32'(o_mem_rden), 32'h1);
    @(negedge clk);
    set_req(0, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    chk("lw4_rsp", 32'(o_rsp_valid), 32'h1);
    chk("lw4_rdata", o_rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Misaligned stores.
    set_req(0, 1, 1, F3_SW, 16'h0001, 32'h11223344);
    #1 model_check(gok, gi);
    chk("sw1_al", 32'(o_mem_bmask_align), 32'hE);
    chk("sw1_mis", 32'(o_mem_bmask_misalign), 32'h1);
    @(negedge clk);
    set_req(0, 1, 1, F3_SH, 16'h0003, 32'h0000A5B6);
    #1 model_check(gok, gi);
    chk("sh3_al", 32'(o_mem_bmask_align), 32'h8);
    chk("sh3_mis", 32'(o_mem_bmask_misalign), 32'h1);
    @(negedge clk);
    set_req(0, 1, 1, F3_SB, 16'h0002, 32'h000000C7);
    #1 model_check(gok, gi);
    chk("sb2_al", 32'(o_mem_bmask_align), 32'h4);
    chk("sb2_mis", 32'(o_mem_bmask_misalign), 32'h0);
    @(negedge clk);

    // Reset, then both ports loading every cycle: alternating grants.
    rst_n = 1'b0; set_req(0, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 0, F3_LW, 16'h0000, 32'h0); set_req(1, 1, 0, F3_LW, 16'h0004, 32'h0);
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b00; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b00;
    exp_rdy[4] = 2'b01; exp_rdy[5] = 2'b00; exp_rdy[6] = 2'b10; exp_rdy[7] = 2'b00;
    exp_rsp[0] = 2'b00; exp_rsp[1] = 2'b01; exp_rsp[2] = 2'b00; exp_rsp[3] = 2'b10;
    exp_rsp[4] = 2'b00; exp_rsp[5] = 2'b01; exp_rsp[6] = 2'b00; exp_rsp[7] = 2'b10;
    for (int c = 0; c < 8; c++) begin
      #1 model_check(gok, gi);
      chk($sformatf("rr_ready%0d", c), 32'(o_req_ready), 32'(exp_rdy[c]));
      chk($sformatf("rr_rsp%0d", c), 32'(o_rsp_valid), 32'(exp_rsp[c]));
      @(negedge clk);
    end

    // Illegal funct3 on port 1.
    set_req(0, 0, 0, 3'd0, 16'h0, 32'h0); set_req(1, 1, 0, 3'b011, 16'h0008, 32'h0);
    #1 model_check(gok, gi);
    chk("ill_en", 32'({o_mem_wren, o_mem_rden}), 32'h0);
    @(negedge clk);
    set_req(1, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    chk("ill_rsp", 32'(o_rsp_valid), 32'h2);
    chk("ill_err", 32'(o_rsp_err), 32'h1);
    chk("ill_rdata", o_rsp_rdata, 32'h0);
    @(negedge clk);

    // Reset while a load response is pending.
    set_req(1, 1, 0, F3_LW, 16'h0004, 32'h0);
    #1 model_check(gok, gi);
    @(negedge clk);
    rst_n = 1'b0; set_req(1, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    chk("rstr_rsp", 32'(o_rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 0, F3_LW, 16'h0000, 32'h0); set_req(1, 1, 0, F3_LW, 16'h0004, 32'h0);
    #1 model_check(gok, gi);
    chk("rstr_first", 32'(o_req_ready), 32'h1);
    chk("rstr_norsp", 32'(o_rsp_valid), 32'h0);
    @(negedge clk);
    set_req(0, 0, 0, 3'd0, 16'h0, 32'h0); set_req(1, 0, 0, 3'd0, 16'h0, 32'h0);
    #1 model_check(gok, gi);
    @(negedge clk);

    // Fixed priority instance: both ports storing for four cycles.
    rst_n = 1'b0;
    #1 model_check(gok, gi);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 1, F3_SW, 16'h0010, 32'h01020304);
    set_req(1, 1, 1, F3_SW, 16'h0020, 32'h0A0B0C0D);
    for (int c = 0; c < 4; c++) begin
      #1 model_check(gok, gi);
      chk($sformatf("fp_ready%0d", c), 32'(fp_ready), 32'h1);
      chk($sformatf("fp_wren%0d", c), 32'({fp_wren, fp_rden}), 32'h2);
      chk($sformatf("fp_addr%0d", c), 32'(fp_addr), 32'h10);
      @(negedge clk);
    end

    // Random traffic; a requester holds its fields until accepted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          pend[p] = ($urandom_range(0, 9) < 6);
          req_we[p]    = $urandom_range(0, 1) == 1;
          req_func3[p] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                      : 3'($urandom_range(0, 2));
          req_addr[p]  = 16'($urandom_range(0, 63));
          req_wdata[p] = $urandom;
        end
        req_valid[p] = pend[p];
      end
      #1 model_check(gok, gi);
      if (gok) pend[gi] = 1'b0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
